// File: rtl/norm_stage.sv
// norm_stage: per-lane normalization ahead of pooling, 2-cycle fixed latency.
// out_i = sat((x_i - mean) * inv_var >>> NORM_SHIFT), bypass passes x_i through.
//
// Ports:
//   clk, reset (async, active low)
//   enable_norm        1 = normalize, 0 = bypass (also forces done_norm high)
//   mean, inv_var      signed offset, unsigned scale, captured with the row
//   in_data_available  row valid; inp_data lane i at [i*DWIDTH +: DWIDTH]
//   validity_mask      bit i = 0 zeroes lane i in normalize mode
//   out_data, out_data_available, done_norm  towards the pooling stage
module norm_stage #(
    parameter int DESIGN_SIZE = 16,
    parameter int DWIDTH      = 8,
    parameter int MASK_WIDTH  = 16,
    parameter int NORM_SHIFT  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable_norm,
    input  logic [DWIDTH-1:0]             mean,
    input  logic [DWIDTH-1:0]             inv_var,
    input  logic                          in_data_available,
    input  logic [DESIGN_SIZE*DWIDTH-1:0] inp_data,
    input  logic [MASK_WIDTH-1:0]         validity_mask,
    output logic [DESIGN_SIZE*DWIDTH-1:0] out_data,
    output logic                          out_data_available,
    output logic                          done_norm
);

    localparam int PW = 2 * (DWIDTH + 1);
    localparam int CW = $clog2(DESIGN_SIZE + 1);
    localparam logic signed [PW-1:0] SAT_HI = PW'((1 << (DWIDTH - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_LO = ~SAT_HI;

    typedef struct packed {
        logic                                valid;
        logic                                mode;
        logic [DWIDTH-1:0]                   inv_var;
        logic [MASK_WIDTH-1:0]               mask;
        logic [DESIGN_SIZE-1:0][DWIDTH:0]    diff;
        logic [DESIGN_SIZE-1:0][DWIDTH-1:0]  x;
    } s1_t;

    typedef struct packed {
        logic                                valid;
        logic                                mode;
        logic [DESIGN_SIZE-1:0][DWIDTH-1:0]  data;
    } s2_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    s1_t    s1_d, s1_q;
    s2_t    s2_d, s2_q;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    logic [DESIGN_SIZE-1:0][DWIDTH:0]   lane_diff;
    logic [DESIGN_SIZE-1:0][DWIDTH-1:0] lane_res;

    // Stage 1 arithmetic: 9-bit difference, cannot overflow.
    for (genvar g = 0; g < DESIGN_SIZE; g++) begin : g_diff
        logic [DWIDTH-1:0] x;
        assign x = inp_data[g*DWIDTH +: DWIDTH];
        assign lane_diff[g] = {x[DWIDTH-1], x} - {mean[DWIDTH-1], mean};
    end

    always_comb begin
        s1_d         = '0;
        s1_d.valid   = in_data_available;
        s1_d.mode    = enable_norm;
        s1_d.inv_var = inv_var;
        s1_d.mask    = validity_mask;
        s1_d.diff    = lane_diff;
        s1_d.x       = inp_data;
    end

    // Stage 2 arithmetic: full product fits PW bits, so no overflow
    // before the shift; >>> on a signed value floors toward -inf.
    for (genvar g = 0; g < DESIGN_SIZE; g++) begin : g_lane
        logic signed [PW-1:0] dx;
        logic signed [PW-1:0] iv;
        logic signed [PW-1:0] prod;
        logic signed [PW-1:0] shr;

        assign dx   = PW'($signed(s1_q.diff[g]));
        assign iv   = PW'({1'b0, s1_q.inv_var});
        assign prod = dx * iv;
        assign shr  = prod >>> NORM_SHIFT;

        always_comb begin
            lane_res[g] = shr[DWIDTH-1:0];
            if (shr > SAT_HI) begin
                lane_res[g] = SAT_HI[DWIDTH-1:0];
            end else if (shr < SAT_LO) begin
                lane_res[g] = SAT_LO[DWIDTH-1:0];
            end
            if (!s1_q.mask[g]) begin
                lane_res[g] = '0;
            end
            if (!s1_q.mode) begin
                lane_res[g] = s1_q.x[g];
            end
        end
    end

    always_comb begin
        s2_d       = '0;
        s2_d.valid = s1_q.valid;
        s2_d.mode  = s1_q.mode;
        s2_d.data  = lane_res;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign out_data           = s2_q.data;
    assign out_data_available = s2_q.valid;

    // Tile tracking counts normalize-mode rows as they leave stage 2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        done_norm = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_data_available) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (s2_q.valid && s2_q.mode) begin
                    cnt_n = cnt + CW'(1);
                    if (cnt_n == CW'(DESIGN_SIZE)) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                done_norm = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // Bypass overrides everything: tile restarts, downstream never waits.
        if (!enable_norm) begin
            state_n   = IDLE;
            cnt_n     = '0;
            done_norm = 1'b1;
        end
    end

endmodule

// File: tb/tb_norm_stage.sv
// tb_norm_stage: randomized and directed checks of norm_stage
// against a lane-arithmetic reference model.
module tb_norm_stage;

    localparam int DS = 16;
    localparam int DW = 8;
    localparam int RW = DS * DW;

    logic          clk;
    logic          reset;
    logic          enable_norm;
    logic [DW-1:0] mean;
    logic [DW-1:0] inv_var;
    logic          in_data_available;
    logic [RW-1:0] inp_data;
    logic [DS-1:0] validity_mask;
    logic [RW-1:0] out_data;
    logic          out_data_available;
    logic          done_norm;

    norm_stage dut (
        .clk               (clk),
        .reset             (reset),
        .enable_norm       (enable_norm),
        .mean              (mean),
        .inv_var           (inv_var),
        .in_data_available (in_data_available),
        .inp_data          (inp_data),
        .validity_mask     (validity_mask),
        .out_data          (out_data),
        .out_data_available(out_data_available),
        .done_norm         (done_norm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit            v;
        bit            mode;
        logic [RW-1:0] d;
    } ent_t;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    ent_t p0, p1;
    bit   m_armed;
    int   m_cnt;

    task automatic chk(string tag, logic [RW-1:0] got, logic [RW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] ref_row(logic [RW-1:0] row,
                                              logic [DW-1:0] m,
                                              logic [DW-1:0] iv,
                                              logic [DS-1:0] mk,
                                              bit mode);
        logic [RW-1:0] res;
        int x, mi, p, r;
        res = '0;
        mi  = int'($signed(m));
        for (int i = 0; i < DS; i++) begin
            x = int'($signed(row[i*DW +: DW]));
            if (!mode) begin
                res[i*DW +: DW] = row[i*DW +: DW];
            end else if (mk[i]) begin
                p = (x - mi) * int'(iv);
                r = (p >= 0) ? p / 16 : -((-p + 15) / 16);
                if (r > 127) r = 127;
                if (r < -128) r = -128;
                res[i*DW +: DW] = 8'(r);
            end
        end
        return res;
    endfunction

    task automatic apply(bit v, bit en, logic [DW-1:0] m, logic [DW-1:0] iv,
                         logic [DS-1:0] mk, logic [RW-1:0] row);
        in_data_available = v;
        enable_norm       = en;
        mean              = m;
        inv_var           = iv;
        validity_mask     = mk;
        inp_data          = row;
    endtask

    task automatic tick();
        ent_t cur;
        bit   en, vin;
        en       = enable_norm;
        vin      = in_data_available;
        cur.v    = vin;
        cur.mode = en;
        cur.d    = ref_row(inp_data, mean, inv_var, validity_mask, en);
        if (!en) begin
            m_armed = 0;
            m_cnt   = 0;
        end else begin
            if (m_armed && m_cnt < DS && p1.v && p1.mode) m_cnt++;
            if (!m_armed && vin) m_armed = 1;
        end
        p1 = p0;
        p0 = cur;
        @(posedge clk);
        #1;
        cyc++;
        chk("valid", RW'(out_data_available), RW'(p1.v));
        if (p1.v) chk("data", out_data, p1.d);
        chk("done", RW'(done_norm), RW'(!enable_norm || m_cnt == DS));
    endtask

    task automatic one_row(string tag, logic [DW-1:0] m, logic [DW-1:0] iv,
                           logic [DS-1:0] mk, logic [RW-1:0] row,
                           logic [RW-1:0] exp);
        apply(1, 1, m, iv, mk, row);
        tick();
        apply(0, 1, m, iv, mk, '0);
        tick();
        chk(tag, out_data, exp);
        chk({tag, "_v"}, RW'(out_data_available), RW'(1));
        tick();
        chk({tag, "_v1"}, RW'(out_data_available), RW'(0));
    endtask

    logic [RW-1:0] row_a, row_b;
    int rise_a, rise_b;

    initial begin
        p0 = '{default: 0};
        p1 = '{default: 0};
        m_armed = 0;
        m_cnt   = 0;
        reset   = 1'b0;
        apply(0, 1, 8'd0, 8'd0, '1, '0);
        #12;
        chk("rst_data", out_data, '0);
        chk("rst_valid", RW'(out_data_available), RW'(0));
        chk("rst_done", RW'(done_norm), RW'(0));
        reset = 1'b1;

        one_row("basic", 8'd10, 8'd32, '1, {DS{8'd20}}, {DS{8'd20}});
        one_row("sat_hi", 8'h80, 8'd255, '1, {DS{8'h7f}}, {DS{8'h7f}});
        one_row("sat_lo", 8'd100, 8'd255, '1, {DS{8'h9c}}, {DS{8'h80}});
        one_row("floor", 8'd6, 8'd1, '1, {DS{8'd5}}, {DS{8'hff}});
        one_row("mask", 8'd10, 8'd32, 16'h00ff, {DS{8'd20}},
                {{8{8'h00}}, {8{8'h14}}});

        for (int i = 0; i < DS; i++) row_a[i*DW +: DW] = 8'(i);
        apply(1, 0, 8'd3, 8'd7, 16'h0, row_a);
        tick();
        apply(0, 0, 8'd3, 8'd7, 16'h0, '0);
        tick();
        chk("bypass", out_data, row_a);
        chk("bypass_done", RW'(done_norm), RW'(1));
        apply(1, 0, 8'd9, 8'd50, '1, ~row_a);
        tick();
        apply(0, 1, 8'd9, 8'd50, '1, '0);
        tick();
        chk("byp_toggle", out_data, ~row_a);

        // 17 back-to-back rows; done expected 18 ticks after the first
        apply(0, 0, 8'd0, 8'd0, '1, '0);
        tick();
        rise_a = 99;
        for (int t = 0; t < 40; t++) begin
            if (t < 17) apply(1, 1, 8'(t), 8'd20, '1, {DS{8'(3 * t)}});
            else apply(0, 1, 8'd0, 8'd0, '1, '0);
            tick();
            if (done_norm && rise_a == 99) rise_a = t + 1;
        end
        chk("done_lat", RW'(rise_a), RW'(18));

        // same burst with a 3-cycle hole after row 8
        apply(0, 0, 8'd0, 8'd0, '1, '0);
        tick();
        rise_b = 99;
        for (int t = 0; t < 40; t++) begin
            if (t < 8 || (t >= 11 && t < 19))
                apply(1, 1, 8'd1, 8'd40, '1, {DS{8'(t)}});
            else apply(0, 1, 8'd0, 8'd0, '1, '0);
            tick();
            if (done_norm && rise_b == 99) rise_b = t + 1;
        end
        chk("done_gap", RW'(rise_b - rise_a), RW'(3));

        // asynchronous reset with two rows in flight
        apply(1, 1, 8'd2, 8'd16, '1, {DS{8'd50}});
        tick();
        apply(1, 1, 8'd2, 8'd16, '1, {DS{8'd60}});
        tick();
        apply(0, 1, 8'd0, 8'd0, '1, '0);
        #3 reset = 1'b0;
        #1;
        chk("arst_data", out_data, '0);
        chk("arst_valid", RW'(out_data_available), RW'(0));
        p0 = '{default: 0};
        p1 = '{default: 0};
        m_armed = 0;
        m_cnt   = 0;
        #2 reset = 1'b1;
        for (int t = 0; t < 4; t++) tick();

        for (int t = 0; t < 400; t++) begin
            row_b = {$urandom, $urandom, $urandom, $urandom};
            apply(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) != 0),
                  8'($urandom), 8'($urandom),
                  ($urandom_range(0, 1) != 0) ? '1 : DS'($urandom), row_b);
            tick();
        end
        apply(0, 1, 8'd0, 8'd0, '1, '0);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
